instr_mem_sync: RTL

//  Parametrised, in-system-programmable instruction memory for the pipelined MIPS core (IF stage).

---
 rtl/mips_pkg.sv | 25 ++
 rtl/imem_ram_sp.sv | 34 +++
 rtl/instr_mem_sync.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core.
//   NOP_WORD   : canonical no-op instruction (sll $zero,$zero,0)
//   IMEM_*     : instruction-memory controller state encoding
//   clog2      : ceiling log2 for sizing index fields from DEPTH
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] IMEM_CLEAR = 2'd0;
    localparam logic [1:0] IMEM_READY = 2'd1;
    localparam logic [1:0] IMEM_PROG  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_ram_sp.sv
// ---------------------------------------------------------------------------
// imem_ram_sp
// Single-port synchronous RAM, DEPTH x DATA_W. Write and read share one
// address. The read register only updates when i_re is high, so the last
// read word is held for as long as the caller needs it.
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write enable (writes i_wdata to word i_addr)
//   i_re     in   read enable (loads word i_addr into o_rdata)
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// ---------------------------------------------------------------------------
module imem_ram_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/instr_mem_sync.sv
// ---------------------------------------------------------------------------
// instr_mem_sync
// In-system-programmable instruction memory for the IF stage. One-cycle
// registered fetch, word-write program port for the boot loader, optional
// sweep to OOR_WORD after reset, and out-of-range / misaligned fetch flags.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   fetch_req/fetch_addr  fetch request and byte address (PC)
//   hold                  pipeline stall, freezes the output registers
//   fetch_ready           a fetch can be accepted this cycle
//   instr/instr_valid     fetched word and its valid flag
//   instr_oor/instr_mis   out-of-range / misaligned flags for that fetch
//   prog_en/prog_we       loader ownership and write strobe
//   prog_addr/prog_data   loader byte address and word
//   busy                  sweeping or being programmed
// ---------------------------------------------------------------------------
module instr_mem_sync
    import mips_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              DEPTH      = 256,
    parameter int              CLEAR_INIT = 1,
    parameter logic [DATA_W-1:0] OOR_WORD = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              hold,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              instr_oor,
    output logic              instr_mis,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy
);

    localparam int IDX_W = clog2(DEPTH);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              r_valid;
    logic              r_oor;
    logic              r_mis;
    logic              r_use_ram;

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_prog_idx;
    logic              w_fetch_oor;
    logic              w_fetch_mis;
    logic              w_prog_ok;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    // Any set bit above the index field makes the address out of range.
    assign w_fetch_idx = fetch_addr[IDX_W+1:2];
    assign w_fetch_oor = |fetch_addr[ADDR_W-1:IDX_W+2];
    assign w_fetch_mis = |fetch_addr[1:0];
    assign w_prog_idx  = prog_addr[IDX_W+1:2];
    assign w_prog_ok   = ~(|prog_addr[ADDR_W-1:IDX_W+2]) & ~(|prog_addr[1:0]);

    assign fetch_ready = (r_state == IMEM_READY) & ~hold & ~prog_en;
    assign w_accept    = fetch_req & fetch_ready;
    assign busy        = (r_state == IMEM_CLEAR) | (r_state == IMEM_PROG);

    // RAM port ownership follows the state; writes are suppressed while
    // reset is asserted so a reset mid-load cannot land a stray word.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = w_fetch_idx;
        w_ram_wdata = prog_data;
        if (reset) begin
            case (r_state)
                IMEM_CLEAR: begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_clr_cnt;
                    w_ram_wdata = OOR_WORD;
                end
                IMEM_PROG: begin
                    w_ram_we   = prog_we & w_prog_ok;
                    w_ram_addr = w_prog_idx;
                end
                default: begin
                    w_ram_re = w_accept & ~w_fetch_oor & ~w_fetch_mis;
                end
            endcase
        end
    end

    imem_ram_sp #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= (CLEAR_INIT != 0) ? IMEM_CLEAR : IMEM_READY;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                IMEM_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (&r_clr_cnt) r_state <= IMEM_READY;
                end
                IMEM_READY: if (prog_en)  r_state <= IMEM_PROG;
                IMEM_PROG:  if (!prog_en) r_state <= IMEM_READY;
                default:    r_state <= IMEM_READY;
            endcase
        end
    end

    // Output stage: the RAM read register doubles as the instruction
    // register; r_use_ram selects it, otherwise OOR_WORD is presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_oor     <= 1'b0;
            r_mis     <= 1'b0;
            r_use_ram <= 1'b0;
        end else if (!hold) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_oor     <= w_fetch_oor;
                r_mis     <= w_fetch_mis;
                r_use_ram <= ~(w_fetch_oor | w_fetch_mis);
            end
        end
    end

    assign instr       = r_use_ram ? w_ram_rdata : OOR_WORD;
    assign instr_valid = r_valid;
    assign instr_oor   = r_oor;
    assign instr_mis   = r_mis;

endmodule
